queue_arbiter: RTL and testbench

QUEUE_ARBITER -- requirements
Module: queue_arbiter

---
 rtl/queue_arbiter_pkg.sv | 20 ++
 rtl/queue_arbiter_rr_arbiter2.sv | 21 ++
 rtl/queue_arbiter.sv | 146 ++++++++++++++
 tb/tb_queue_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_arbiter_pkg.sv
// Shared definitions for queue_arbiter: FSM states, one-hot grant encodings
// and parameter defaults.
package queue_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENQ     = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // grant_out is one-hot: bit0 = producer A, bit1 = producer B
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

    localparam int unsigned DEPTH_DEFAULT   = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/queue_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way combinational round-robin pick. A lone request always
// wins; on a tie the side named by prio_b_i wins.
module rr_arbiter2
    import queue_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_b_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        case (req_i)
            2'b01:   gnt_o = GNT_A;
            2'b10:   gnt_o = GNT_B;
            2'b11:   gnt_o = prio_b_i ? GNT_B : GNT_A;
            default: gnt_o = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/queue_arbiter.sv
// queue_arbiter: round-robin arbiter moving bytes from two producers into a queue.
// Define QUEUE_ARBITER_TIMEOUT_EN to compile in the ENQ watchdog and sticky err_out.
module queue_arbiter
    import queue_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ready_a,
    input  logic       ready_b,
    input  logic [7:0] data_a,
    input  logic [7:0] data_b,
    input  logic [3:0] len_in,
    output logic       ack_a,
    output logic       ack_b,
    output logic       enqueue_out,
    output logic [7:0] data_out,
    output logic [1:0] grant_out,
    output logic       full_out,
    output logic       err_out
);

    localparam logic [4:0] DEPTH_CMP = 5'(DEPTH);

    // The watchdog limit must fit the 8-bit ENQ counter.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("queue_arbiter: TIMEOUT must be in 1..255");
    end

    state_e     state_q,  state_d;
    logic [1:0] grant_q,  grant_d;
    logic [7:0] data_q,   data_d;
    logic [3:0] snap_q,   snap_d;
    logic       prio_b_q, prio_b_d;
    logic [1:0] rr_gnt;
    logic       granted_ready;

`ifdef QUEUE_ARBITER_TIMEOUT_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
`endif

    assign full_out      = ({1'b0, len_in} >= DEPTH_CMP);
    assign granted_ready = |(grant_q & {ready_b, ready_a});
    assign data_out      = data_q;
    assign grant_out     = grant_q;

    rr_arbiter2 u_rr (
        .req_i    ({ready_b, ready_a}),
        .prio_b_i (prio_b_q),
        .gnt_o    (rr_gnt)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        data_d      = data_q;
        snap_d      = snap_q;
        prio_b_d    = prio_b_q;
        enqueue_out = 1'b0;
        ack_a       = 1'b0;
        ack_b       = 1'b0;
`ifdef QUEUE_ARBITER_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!full_out && (ready_a || ready_b)) begin
                    grant_d = rr_gnt;
                    data_d  = rr_gnt[1] ? data_b : data_a;
                    snap_d  = len_in;
                    state_d = ENQ;
`ifdef QUEUE_ARBITER_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            ENQ: begin
                enqueue_out = 1'b1;
                // Any change of occupancy (push or concurrent pop) ends the enqueue.
                if (len_in != snap_q) begin
                    state_d = ACK;
                end
`ifdef QUEUE_ARBITER_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    err_d   = 1'b1;
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            ACK: begin
                ack_a    = grant_q[0];
                ack_b    = grant_q[1];
                prio_b_d = grant_q[0];
                state_d  = RELEASE;
            end
            RELEASE: begin
                if (!granted_ready) begin
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= GNT_NONE;
            data_q   <= '0;
            snap_q   <= '0;
            prio_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            snap_q   <= snap_d;
            prio_b_q <= prio_b_d;
        end
    end

`ifdef QUEUE_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_queue_arbiter.sv
// Bench for queue_arbiter: directed scenarios followed by randomized transfers
// checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_queue_arbiter;
    import queue_arbiter_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic [3:0] len_in;
    logic       ack_a, ack_b, enqueue_out, full_out, err_out;
    logic [7:0] data_out;
    logic [1:0] grant_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          last_b;   // B completed the latest transfer, so A wins a tie

    always #5 clk = ~clk;

    queue_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ready_a     (ready_a),
        .ready_b     (ready_b),
        .data_a      (data_a),
        .data_b      (data_b),
        .len_in      (len_in),
        .ack_a       (ack_a),
        .ack_b       (ack_b),
        .enqueue_out (enqueue_out),
        .data_out    (data_out),
        .grant_out   (grant_out),
        .full_out    (full_out),
        .err_out     (err_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] rr_expect(input logic ra, input logic rb, input bit favour_b);
        if (ra && rb) return favour_b ? GNT_B : GNT_A;
        if (ra) return GNT_A;
        if (rb) return GNT_B;
        return GNT_NONE;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drop(input logic [1:0] g);
        if (g == GNT_B) ready_b = 1'b0;
        else ready_a = 1'b0;
    endtask

    // Called at a falling edge with the DUT idle and inputs already applied.
    task automatic run_xfer(input logic [1:0] exp_g, input logic [3:0] new_len,
                            input int unsigned enq_hold, input bit drop_in_enq,
                            input int unsigned rel_hold);
        logic [7:0] exp_d;
        exp_d = (exp_g == GNT_B) ? data_b : data_a;
        step();
        check_eq("grant", 32'(grant_out), 32'(exp_g));
        check_eq("data_out", 32'(data_out), 32'(exp_d));
        check_eq("enqueue", 32'(enqueue_out), 32'd1);
        for (int unsigned i = 0; i < enq_hold; i++) begin
            if (drop_in_enq && i == 0) drop(exp_g);
            step();
            check_eq("enq_hold", 32'(enqueue_out), 32'd1);
            check_eq("enq_no_ack", 32'({ack_b, ack_a}), 32'd0);
            check_eq("enq_data", 32'(data_out), 32'(exp_d));
        end
        if (drop_in_enq && enq_hold == 0) drop(exp_g);
        len_in = new_len;
        step();
        check_eq("ack_enq_low", 32'(enqueue_out), 32'd0);
        check_eq("ack", 32'({ack_b, ack_a}), 32'(exp_g));
        last_b = (exp_g == GNT_B);
        step();
        check_eq("ack_single", 32'({ack_b, ack_a}), 32'd0);
        check_eq("release_grant", 32'(grant_out), 32'(exp_g));
        if ((exp_g == GNT_B) ? ready_b : ready_a) begin
            for (int unsigned i = 0; i < rel_hold; i++) begin
                step();
                check_eq("release_hold", 32'(grant_out), 32'(exp_g));
            end
            drop(exp_g);
        end
        step();
        check_eq("idle_grant", 32'(grant_out), 32'd0);
        check_eq("idle_ack", 32'({ack_b, ack_a}), 32'd0);
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [3:0]  new_len;
        int unsigned hold;
`ifdef QUEUE_ARBITER_TIMEOUT_EN
        bit saw_ack;
`endif
        reset_n = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        len_in  = '0;
        last_b  = 1'b1;
        repeat (2) step();
        check_eq("rst_grant", 32'(grant_out), 32'd0);
        check_eq("rst_enq", 32'(enqueue_out), 32'd0);
        check_eq("rst_ack", 32'({ack_b, ack_a}), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_err", 32'(err_out), 32'd0);
        check_eq("rst_full", 32'(full_out), 32'd0);
        reset_n = 1'b1;
        step();

        // Single producer, occupancy 0 -> 3
        ready_a = 1'b1;
        data_a  = 8'h5A;
        run_xfer(GNT_A, 4'd3, 0, 1'b0, 1);

        // Full queue blocks the grant until occupancy drops
        ready_b = 1'b1;
        data_b  = 8'hC3;
        len_in  = 4'd8;
        repeat (50) begin
            step();
            check_eq("full_no_grant", 32'(grant_out), 32'd0);
        end
        check_eq("full_flag", 32'(full_out), 32'd1);
        len_in = 4'd7;
        check_eq("not_full_flag", 32'(full_out), 32'd0);
        run_xfer(GNT_B, 4'd8, 1, 1'b0, 0);

        // Contention: both requesting, grants alternate A,B,A,B
        len_in = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (!ready_a) begin ready_a = 1'b1; data_a = 8'($urandom); end
            if (!ready_b) begin ready_b = 1'b1; data_b = 8'($urandom); end
            run_xfer((i % 2 == 0) ? GNT_A : GNT_B, 4'(len_in + 4'd1), 32'(i), 1'b0, 0);
        end
        ready_a = 1'b0;

        // Frozen occupancy during ENQ
        ready_a = 1'b1;
        data_a  = 8'hE7;
`ifdef QUEUE_ARBITER_TIMEOUT_EN
        step();
        check_eq("to_grant", 32'(grant_out), 32'(GNT_A));
        saw_ack = 1'b0;
        repeat (TIMEOUT - 1) begin
            step();
            if (ack_a || ack_b) saw_ack = 1'b1;
        end
        check_eq("to_enq_last", 32'(enqueue_out), 32'd1);
        check_eq("to_err_early", 32'(err_out), 32'd0);
        step();
        ready_a = 1'b0;
        check_eq("to_err", 32'(err_out), 32'd1);
        check_eq("to_enq_drop", 32'(enqueue_out), 32'd0);
        check_eq("to_grant_clr", 32'(grant_out), 32'd0);
        check_eq("to_no_ack", 32'(saw_ack | ack_a | ack_b), 32'd0);
        repeat (3) step();
        check_eq("to_err_sticky", 32'(err_out), 32'd1);
        ready_a = 1'b1;
        ready_b = 1'b1;
        data_b  = 8'h3C;
        run_xfer(rr_expect(ready_a, ready_b, !last_b), 4'(len_in + 4'd1), 0, 1'b0, 0);
        ready_a = 1'b0;
        ready_b = 1'b0;
`else
        run_xfer(GNT_A, 4'(len_in + 4'd1), 1000, 1'b0, 0);
        check_eq("no_wd_err", 32'(err_out), 32'd0);
`endif

        // Reset during ENQ abandons the transfer and restores A priority
        ready_a = 1'b1;
        data_a  = 8'h11;
        run_xfer(GNT_A, 4'(len_in - 4'd1), 1, 1'b0, 0);
        ready_b = 1'b1;
        data_b  = 8'h22;
        step();
        check_eq("pre_rst_grant", 32'(grant_out), 32'(GNT_B));
        check_eq("pre_rst_enq", 32'(enqueue_out), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_grant", 32'(grant_out), 32'd0);
        check_eq("arst_enq", 32'(enqueue_out), 32'd0);
        check_eq("arst_data", 32'(data_out), 32'd0);
        check_eq("arst_ack", 32'({ack_b, ack_a}), 32'd0);
        check_eq("arst_err", 32'(err_out), 32'd0);
        step();
        check_eq("rst_hold_ack", 32'({ack_b, ack_a}), 32'd0);
        check_eq("rst_hold_grant", 32'(grant_out), 32'd0);
        reset_n = 1'b1;
        last_b  = 1'b1;
        ready_a = 1'b1;
        data_a  = 8'h33;
        run_xfer(GNT_A, 4'(len_in + 4'd1), 0, 1'b0, 0);

        // Randomized traffic against the round-robin model
        for (int r = 0; r < 200; r++) begin
            if (!ready_a && $urandom_range(0, 1) == 1) begin ready_a = 1'b1; data_a = 8'($urandom); end
            if (!ready_b && $urandom_range(0, 1) == 1) begin ready_b = 1'b1; data_b = 8'($urandom); end
            if (!ready_a && !ready_b) begin ready_a = 1'b1; data_a = 8'($urandom); end
            if ($urandom_range(0, 3) == 0) begin
                len_in = 4'($urandom_range(DEPTH, 15));
                hold = $urandom_range(1, 5);
                repeat (hold) begin
                    step();
                    check_eq("rnd_full_grant", 32'(grant_out), 32'd0);
                    check_eq("rnd_full_flag", 32'(full_out), 32'd1);
                end
            end
            len_in  = 4'($urandom_range(0, DEPTH - 1));
            exp_g   = rr_expect(ready_a, ready_b, !last_b);
            new_len = (len_in != 4'd0 && $urandom_range(0, 1) == 1) ? 4'(len_in - 4'd1)
                                                                   : 4'(len_in + 4'd1);
            run_xfer(exp_g, new_len, $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
